// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - drives a two-input gate through all four vectors and checks c against TRUTH
module gate_exerciser #(
  parameter logic [3:0] TRUTH      = 4'b0111,
  parameter int         SETTLE_CYC = 2,
  parameter int         PASSES     = 1,
  parameter int         ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a,
  output logic             b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail
);

  typedef enum logic [1:0] {IDLE, HOLD, FIN} state_t;

  localparam logic [7:0] SETTLE_C  = 8'(SETTLE_CYC);
  localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

  state_t           state_q;
  logic [1:0]       vec_q;
  logic [7:0]       hold_q;
  logic [7:0]       pass_cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [1:0]       ff_q;
  logic             a_q, b_q, busy_q, done_q, pass_q;
  logic             mismatch;
  logic [1:0]       vec_nxt;

  always_comb begin
    mismatch = (c_in != TRUTH[vec_q]);
    vec_nxt  = vec_q + 2'd1;
    err_d    = err_q;
    // Saturate rather than wrap so a bad gate can never read back as clean.
    if (mismatch && (err_q != {ERR_W{1'b1}}))
      err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= 2'd0;
      hold_q     <= 8'd0;
      pass_cnt_q <= 8'd0;
      err_q      <= '0;
      ff_q       <= 2'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        a_q     <= 1'b0;
        b_q     <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              err_q      <= '0;
              ff_q       <= 2'd0;
              vec_q      <= 2'd0;
              pass_cnt_q <= 8'd0;
              hold_q     <= 8'd0;
              a_q        <= 1'b0;
              b_q        <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= HOLD;
            end
          end
          HOLD: begin
            if (hold_q == SETTLE_C) begin
              err_q  <= err_d;
              hold_q <= 8'd0;
              if (mismatch && (err_q == '0))
                ff_q <= vec_q;
              if ((vec_q == 2'd3) && (pass_cnt_q == PASS_LAST)) begin
                state_q <= FIN;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (err_d == '0);
                a_q     <= 1'b0;
                b_q     <= 1'b0;
              end else begin
                vec_q <= vec_nxt;
                a_q   <= vec_nxt[1];
                b_q   <= vec_nxt[0];
                if (vec_q == 2'd3)
                  pass_cnt_q <= pass_cnt_q + 8'd1;
              end
            end else begin
              hold_q <= hold_q + 8'd1;
            end
          end
          FIN: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// tb/tb_gate_exerciser.sv - scoreboard bench for gate_exerciser across three parameterisations
module tb_gate_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       abort;
  logic       start_v [3];
  logic       a_w [3], b_w [3], c_w [3], busy_w [3], done_w [3], pass_w [3];
  logic [1:0] ff_w [3];
  logic [7:0] err0, err1;
  logic [0:0] err2;
  int         mode [3];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       pass;
    logic [7:0] err;
    logic [1:0] ff;
  } res_t;

  res_t       sb_q [$];
  logic [1:0] ab_q [$];

  int         sel;
  logic       s_busy, s_done, s_pass, s_a, s_b;
  logic [7:0] s_err;
  logic [1:0] s_ff;

  // mode 0 = NAND, 1 = AND, 2 = stuck-at-1
  function automatic logic gate(input int m, input logic [1:0] v);
    case (m)
      0:       return ~(v[1] & v[0]);
      1:       return v[1] & v[0];
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) c_w[i] = gate(mode[i], {a_w[i], b_w[i]});
  end

  always_comb begin
    s_busy = busy_w[sel];
    s_done = done_w[sel];
    s_pass = pass_w[sel];
    s_a    = a_w[sel];
    s_b    = b_w[sel];
    s_ff   = ff_w[sel];
    s_err  = (sel == 0) ? err0 : (sel == 1) ? err1 : {7'b0, err2};
  end

  gate_exerciser u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort),
    .a(a_w[0]), .b(b_w[0]), .c_in(c_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .err_count(err0), .first_fail(ff_w[0])
  );

  gate_exerciser #(.PASSES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort),
    .a(a_w[1]), .b(b_w[1]), .c_in(c_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .err_count(err1), .first_fail(ff_w[1])
  );

  gate_exerciser #(.PASSES(2), .ERR_W(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort),
    .a(a_w[2]), .b(b_w[2]), .c_in(c_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .pass(pass_w[2]), .err_count(err2), .first_fail(ff_w[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input int s, input int passes, input int errmax, input bit noisy);
    res_t       r;
    int         cnt;
    logic [1:0] v;
    sel   = s;
    r.err = 8'd0;
    r.ff  = 2'd0;
    for (int p = 0; p < passes; p++) begin
      for (int vi = 0; vi < 4; vi++) begin
        v = vi[1:0];
        for (int k = 0; k < 3; k++) ab_q.push_back(v);
        if (gate(mode[s], v) !== gate(0, v)) begin
          if (r.err == 8'd0) r.ff = v;
          if (int'(r.err) < errmax) r.err = r.err + 8'd1;
        end
      end
    end
    r.pass = (r.err == 8'd0);
    sb_q.push_back(r);

    @(negedge clk) start_v[s] = 1'b1;
    @(negedge clk) start_v[s] = 1'b0;
    check("err_cleared_on_start", s_err, 0);
    check("ff_cleared_on_start", s_ff, 0);
    cnt = 0;
    while (s_busy === 1'b1 && cnt < 200) begin
      if (ab_q.size() > 0) check("ab_sequence", {s_a, s_b}, ab_q.pop_front());
      start_v[s] = (noisy && (cnt == 4 || cnt == 8));
      cnt++;
      @(negedge clk);
    end
    start_v[s] = 1'b0;
    ab_q.delete();
    check("busy_cycles", cnt, passes * 12);
    check("done_pulse", s_done, 1);
    check("fin_ab", {s_a, s_b}, 0);
    r = sb_q.pop_front();
    check("pass_result", s_pass, r.pass);
    check("err_count", s_err, r.err);
    check("first_fail", s_ff, r.ff);
    @(negedge clk);
    check("done_one_cycle", s_done, 0);
    check("idle_after_fin", s_busy, 0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    mode[0] = 0; mode[1] = 2; mode[2] = 1;
    sel = 0;
    #12;
    check("rst_busy", s_busy, 0);
    check("rst_ab", {s_a, s_b}, 0);
    check("rst_done", s_done, 0);
    check("rst_pass", s_pass, 0);
    check("rst_err", s_err, 0);
    check("rst_ff", s_ff, 0);
    @(negedge clk) rst_n = 1'b1;

    mode[0] = 1;
    do_run(0, 1, 255, 1'b0);
    mode[0] = 0;
    do_run(0, 1, 255, 1'b1);
    do_run(1, 2, 255, 1'b0);
    do_run(2, 2, 1, 1'b0);

    // abort during vector 10 with an AND gate attached
    mode[0] = 1;
    sel = 0;
    @(negedge clk) start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    cnt = 0;
    while ({s_a, s_b} !== 2'b10 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_vec10", {s_a, s_b}, 2'b10);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_busy", s_busy, 0);
    check("abort_ab", {s_a, s_b}, 0);
    check("abort_pass_kept", s_pass, 1);
    check("abort_err_kept", s_err, 2);
    check("abort_ff_kept", s_ff, 0);
    for (int i = 0; i < 5; i++) begin
      check("abort_no_done", s_done, 0);
      @(negedge clk);
    end
    abort = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start_v[0] = 1'b0;
    check("abort_start_idle", s_busy, 0);
    check("abort_start_err", s_err, 2);
    mode[0] = 0;
    do_run(0, 1, 255, 1'b0);

    // asynchronous reset mid-run
    mode[0] = 1;
    @(negedge clk) start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", s_busy, 1);
    check("pre_reset_err", s_err, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", s_busy, 0);
    check("async_rst_ab", {s_a, s_b}, 0);
    check("async_rst_done", s_done, 0);
    check("async_rst_pass", s_pass, 0);
    check("async_rst_err", s_err, 0);
    check("async_rst_ff", s_ff, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_done", s_done, 0);
      check("post_rst_idle", s_busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
